// File: rtl/mult_seq_n.sv
// Sequential shift-and-add multiplier with optional early exit.
// Signed operands are handled as magnitudes, and the product is negated on the way out.
// The result register keeps the previous product while a new multiplication runs.
module mult_seq_n #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_A,
    input  logic [WIDTH-1:0]     op_B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              init_q;
    logic              start;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     result_q, result_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [PW-1:0]     acc_sum;
    logic [WIDTH-1:0]  mplier_shr;
    logic              last_iter;

    // A held init level only starts one multiplication.
    assign start = init & ~init_q;

    // Operand magnitudes and the per-iteration add/shift datapath.
    always_comb begin
        mag_a      = (signed_mode && op_A[WIDTH-1]) ? -op_A : op_A;
        mag_b      = (signed_mode && op_B[WIDTH-1]) ? -op_B : op_B;
        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shr = mplier_q >> 1;
        last_iter  = (cnt_q == CW'(1)) || ((EARLY_EXIT != 0) && (mplier_shr == '0));
    end

    // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the case infers a latch.
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = signed_mode & (op_A[WIDTH-1] ^ op_B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q - CW'(1);
                if (last_iter) begin
                    result_d = neg_q ? -acc_sum : acc_sum;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // done is registered out of DONE, so it rises one cycle after the result loads.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge detector and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the datapath registers are reset too, so an aborted run leaves no stale operands behind.
        if (reset) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            state_q  <= state_d;
            init_q   <= init;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: doc/mult_seq_n.md
MULT_SEQ_N -- requirements
Module: mult_seq_n

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Parameter EARLY_EXIT, default 1; 1 ends iteration once the remaining multiplier bits are zero, 0 always runs WIDTH iterations.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 init  input  1  start request; rising-edge detected.
REQ-006 signed_mode  input  1  1 means two's-complement operands, 0 means unsigned; sampled with operands.
REQ-007 op_A  input  WIDTH  multiplicand.
REQ-008 op_B  input  WIDTH  multiplier.
REQ-009 result  output  2*WIDTH  product; registered.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 busy  output  1  high while a multiplication is in progress.

Function
REQ-012 The block SHALL register init every cycle (init_q) and define start = init & ~init_q; a level held high SHALL NOT retrigger.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE: on start, the block SHALL latch op_A, op_B and signed_mode, clear the accumulator, load the iteration counter, and enter CALC.
REQ-015 In signed_mode, operand magnitudes SHALL be latched (|x| as WIDTH-bit unsigned, so -2^(WIDTH-1) gives 2^(WIDTH-1)), and the sign flag SHALL be sign(A) XOR sign(B).
REQ-016 Each CALC cycle: if multiplier bit0 is 1, add the 2*WIDTH-bit shifted multiplicand to the accumulator; then shift the multiplicand left by 1, shift the multiplier right by 1, and decrement the counter.
REQ-017 CALC SHALL go to DONE after WIDTH iterations, or, when EARLY_EXIT=1, after the first iteration that leaves the shifted multiplier equal to zero; the minimum is 1 iteration.
REQ-018 On the CALC to DONE transition, result SHALL be loaded with the accumulator, or its two's-complement negation when the sign flag is 1, modulo 2^(2*WIDTH).
REQ-019 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-021 result SHALL hold its value from the DONE cycle until the next CALC to DONE transition; it SHALL NOT change during a new computation.
REQ-022 A start occurring in CALC or DONE SHALL be ignored, with no queuing; init_q SHALL still track init.
REQ-023 Latency: with the start edge sampled at edge 0, done SHALL be high after edge N+1, where N = iteration count (WIDTH, or max(1, msb index of |op_B| + 1) with EARLY_EXIT).
REQ-024 op_A, op_B and signed_mode changes after the start edge SHALL NOT affect the in-flight result.

Reset
REQ-025 reset high SHALL immediately force state IDLE, result 0, done 0, busy 0, init_q 0, and clear all datapath registers, regardless of clock.
REQ-026 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After reset release, init already high at the first rising edge SHALL count as a start, since init_q resets to 0.

Verification
REQ-028 WIDTH=16, unsigned: op_A=0x0055, op_B=0x0033, init held high for 2 cycles -> result=0x000010EF; done pulses once; EARLY_EXIT=1 gives 6 iterations with done 7 cycles after start; no second run.
REQ-029 WIDTH=16, unsigned: op_A=0xFFFF, op_B=0xFFFF -> result=0xFFFE0001; 16 iterations; done 17 cycles after start.
REQ-030 WIDTH=16, signed: op_A=0xFFFD (-3), op_B=0x0005 -> result=0xFFFFFFF1; op_A=op_B=0x8000 -> result=0x40000000.
REQ-031 op_B=0x0000, EARLY_EXIT=1: result=0 and done 2 cycles after start; with EARLY_EXIT=0, done 17 cycles after start.
REQ-032 Reset pulsed at iteration 5 of a 16-iteration run -> busy=0 and result=0 immediately, no done pulse; a fresh start then completes normally.
REQ-033 Second init edge issued during CALC -> ignored, exactly one done; a random regression of 1000 signed and unsigned vectors for WIDTH 8, 16 and 32 matches the reference model.
